// File: rtl/fila_pkg.sv
// Shared types and defaults for the fila byte FIFO that sits behind the deserializer.
// Imported by the interface, the storage array and the FIFO top.
package fila_pkg;

    localparam int DEFAULT_DEPTH = 8;
    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        WAIT_LOW
    } fila_state_t;

endpackage

// File: rtl/fila_if.sv
// Deserializer/consumer side of the fila FIFO; the FIFO itself uses the slave modport.
// master drives the word, its data_ready level and the consumer pop.
interface fila_if #(
    parameter int DEPTH = fila_pkg::DEFAULT_DEPTH,
    parameter int WIDTH = fila_pkg::DEFAULT_WIDTH
);
    localparam int LEN_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_in;
    logic             enqueue_in;
    logic             ack_out;
    logic             dequeue_in;
    logic [WIDTH-1:0] data_out;
    logic [LEN_W-1:0] len_out;

    modport master (
        output data_in,
        output enqueue_in,
        output dequeue_in,
        input  ack_out,
        input  data_out,
        input  len_out
    );

    modport slave (
        input  data_in,
        input  enqueue_in,
        input  dequeue_in,
        output ack_out,
        output data_out,
        output len_out
    );

endinterface

// File: rtl/fila_ram.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
// The FIFO reads at head, so a pop in the same cycle as a write sees the old contents.
module fila_ram
    import fila_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             clock_10KHz,
    input  logic             wr_en,
    input  logic [PW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [PW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset; occupancy is tracked by len, so stale words are never
    // observable, and leaving it unreset keeps it a plain register file. Non-blocking
    // assignment here so the async read below sees the pre-edge value in the same cycle.
    always_ff @(posedge clock_10KHz) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fila_fifo.sv
// Byte FIFO capturing deserializer words with a level/ack handshake, popped by a consumer.
// Define FILA_OVERWRITE_EN to drop the oldest word instead of stalling when full.
module fila_fifo
    import fila_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clock_10KHz,
    input  logic reset,
    fila_if.slave bus
);

    localparam int PW    = $clog2(DEPTH);
    localparam int LEN_W = $clog2(DEPTH + 1);
    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(DEPTH);

    fila_state_t      state;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [LEN_W-1:0] len;
    logic             ack_q;
    logic [WIDTH-1:0] data_out_q;
    logic [WIDTH-1:0] rd_data;

    logic do_pop;
    logic do_push;
    logic drop;
    logic full;
    logic space;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        do_pop  = 1'b0;
        do_push = 1'b0;
        drop    = 1'b0;
        full    = (len == FULL_LEN);
        do_pop  = bus.dequeue_in && (len != '0);
        space   = !full || do_pop;
`ifdef FILA_OVERWRITE_EN
        drop    = (state == IDLE) && bus.enqueue_in && full && !bus.dequeue_in;
`endif
        do_push = (state == IDLE) && bus.enqueue_in && (space || drop);
    end

    always_ff @(posedge clock_10KHz) begin
        if (reset) begin
            state      <= IDLE;
            head       <= '0;
            tail       <= '0;
            len        <= '0;
            ack_q      <= 1'b0;
            data_out_q <= '0;
        end else begin
            if (do_pop) begin
                data_out_q <= rd_data;
            end
            // An overwrite retires the oldest slot without presenting it on data_out.
            if (do_pop || drop) begin
                head <= head + PW'(1);
            end
            if (do_push) begin
                tail <= tail + PW'(1);
            end

            case ({do_push && !drop, do_pop})
                2'b10:   len <= len + LEN_W'(1);
                2'b01:   len <= len - LEN_W'(1);
                default: len <= len;
            endcase

            case (state)
                IDLE: begin
                    if (do_push) begin
                        ack_q <= 1'b1;
                        state <= ACK;
                    end
                end
                ACK: begin
                    ack_q <= 1'b0;
                    state <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    // Wait for data_ready to fall so a held level is not captured twice.
                    if (!bus.enqueue_in) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    ack_q <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    fila_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .clock_10KHz (clock_10KHz),
        .wr_en       (do_push),
        .wr_addr     (tail),
        .wr_data     (bus.data_in),
        .rd_addr     (head),
        .rd_data     (rd_data)
    );

    assign bus.ack_out  = ack_q;
    assign bus.data_out = data_out_q;
    assign bus.len_out  = len;

endmodule

// File: tb/tb_fila_fifo.sv
// Self-checking bench for fila_fifo: a per-cycle vector table for the handshake and
// empty-pop cases, plus scoreboard-driven sequences for ordering, full and reset corners.
module tb_fila_fifo;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;

    logic clock_10KHz;
    logic reset;

    fila_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    fila_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock_10KHz (clock_10KHz),
        .reset       (reset),
        .bus         (bus.slave)
    );

    initial clock_10KHz = 1'b0;
    always #50 clock_10KHz = ~clock_10KHz;

    typedef struct {
        string      name;
        logic       enq;
        logic       deq;
        logic [7:0] din;
        logic       exp_ack;
        int         exp_len;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t       vecs [10];
    logic [7:0] sb [$];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one rising edge and let outputs settle before sampling.
    task automatic tick();
        @(posedge clock_10KHz);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        bus.enqueue_in = 1'b0;
        bus.dequeue_in = 1'b0;
        bus.data_in    = '0;
        tick();
        tick();
        reset = 1'b0;
        sb.delete();
        check("reset ack", 32'(bus.ack_out), 32'd0);
        check("reset len", 32'(bus.len_out), 32'd0);
        check("reset dout", 32'(bus.data_out), 32'd0);
    endtask

    // Full handshake for one word; the model records it once the capture is expected.
    task automatic push_word(input logic [7:0] d);
        bus.data_in    = d;
        bus.enqueue_in = 1'b1;
        tick();
        check($sformatf("push %02h ack", d), 32'(bus.ack_out), 32'd1);
        sb.push_back(d);
        bus.enqueue_in = 1'b0;
        tick();
        check($sformatf("push %02h ack low", d), 32'(bus.ack_out), 32'd0);
        tick();
        check($sformatf("push %02h len", d), 32'(bus.len_out), 32'(sb.size()));
    endtask

    task automatic pop_word();
        logic [7:0] exp;
        bus.dequeue_in = 1'b1;
        tick();
        bus.dequeue_in = 1'b0;
        if (sb.size() == 0) begin
            check("pop underflow in model", 32'd1, 32'd0);
        end else begin
            exp = sb.pop_front();
            check($sformatf("pop data %02h", exp), 32'(bus.data_out), 32'(exp));
            check("pop len", 32'(bus.len_out), 32'(sb.size()));
        end
    endtask

    task automatic fill_01_to_08();
        for (int i = 1; i <= DEPTH; i++) begin
            push_word(8'(i));
        end
        check("full len", 32'(bus.len_out), 32'(DEPTH));
    endtask

    initial begin
        logic [7:0] dout_before;

        // Capture latency, held data_ready, then pops including one on an empty FIFO.
        vecs[0] = '{"cap A5",        1'b1, 1'b0, 8'hA5, 1'b1, 1, 8'h00};
        vecs[1] = '{"hold 1",        1'b1, 1'b0, 8'hA5, 1'b0, 1, 8'h00};
        vecs[2] = '{"hold 2",        1'b1, 1'b0, 8'hA5, 1'b0, 1, 8'h00};
        vecs[3] = '{"hold 3",        1'b1, 1'b0, 8'hA5, 1'b0, 1, 8'h00};
        vecs[4] = '{"hold 4",        1'b1, 1'b0, 8'hA5, 1'b0, 1, 8'h00};
        vecs[5] = '{"hold 5",        1'b1, 1'b0, 8'hA5, 1'b0, 1, 8'h00};
        vecs[6] = '{"release",       1'b0, 1'b0, 8'h00, 1'b0, 1, 8'h00};
        vecs[7] = '{"pop A5",        1'b0, 1'b1, 8'h00, 1'b0, 0, 8'hA5};
        vecs[8] = '{"pop empty",     1'b0, 1'b1, 8'h00, 1'b0, 0, 8'hA5};
        vecs[9] = '{"idle after",    1'b0, 1'b0, 8'h00, 1'b0, 0, 8'hA5};

        reset          = 1'b1;
        bus.enqueue_in = 1'b0;
        bus.dequeue_in = 1'b0;
        bus.data_in    = '0;

        do_reset();
        for (int i = 0; i < 10; i++) begin
            bus.enqueue_in = vecs[i].enq;
            bus.dequeue_in = vecs[i].deq;
            bus.data_in    = vecs[i].din;
            tick();
            check({vecs[i].name, " ack"},  32'(bus.ack_out),  32'(vecs[i].exp_ack));
            check({vecs[i].name, " len"},  32'(bus.len_out),  32'(vecs[i].exp_len));
            check({vecs[i].name, " dout"}, 32'(bus.data_out), 32'(vecs[i].exp_dout));
        end
        bus.dequeue_in = 1'b0;

        // In-order delivery through a full wrap of the pointers.
        do_reset();
        fill_01_to_08();
        for (int i = 0; i < DEPTH; i++) pop_word();
        check("drained len", 32'(bus.len_out), 32'd0);
        // Pointers now sit at DEPTH-1 -> 0 wrap; an empty pop must not disturb anything.
        bus.dequeue_in = 1'b1;
        tick();
        bus.dequeue_in = 1'b0;
        check("empty pop dout", 32'(bus.data_out), 32'h08);
        check("empty pop len", 32'(bus.len_out), 32'd0);
        push_word(8'h3C);
        pop_word();

        // Push while full.
        do_reset();
        fill_01_to_08();
        dout_before    = bus.data_out;
        bus.data_in    = 8'hFF;
        bus.enqueue_in = 1'b1;
        tick();
`ifdef FILA_OVERWRITE_EN
        check("ovw ack", 32'(bus.ack_out), 32'd1);
        check("ovw len", 32'(bus.len_out), 32'(DEPTH));
        check("ovw dout unchanged", 32'(bus.data_out), 32'(dout_before));
        void'(sb.pop_front());
        sb.push_back(8'hFF);
        bus.enqueue_in = 1'b0;
        tick();
        tick();
`else
        check("full block ack", 32'(bus.ack_out), 32'd0);
        check("full block len", 32'(bus.len_out), 32'(DEPTH));
        tick();
        check("full block ack 2", 32'(bus.ack_out), 32'd0);
        // A pop frees the slot; the still-pending word is captured in that same edge.
        bus.dequeue_in = 1'b1;
        tick();
        bus.dequeue_in = 1'b0;
        check("unblock ack", 32'(bus.ack_out), 32'd1);
        check("unblock pop data", 32'(bus.data_out), 32'h01);
        check("unblock len", 32'(bus.len_out), 32'(DEPTH));
        void'(sb.pop_front());
        sb.push_back(8'hFF);
        bus.enqueue_in = 1'b0;
        tick();
        tick();
`endif
        for (int i = 0; i < DEPTH; i++) pop_word();
        check("after full len", 32'(bus.len_out), 32'd0);

        // Simultaneous push+pop when full, then reset in ACK with data_ready still high.
        do_reset();
        fill_01_to_08();
        bus.data_in    = 8'h55;
        bus.enqueue_in = 1'b1;
        bus.dequeue_in = 1'b1;
        tick();
        bus.dequeue_in = 1'b0;
        check("swap ack", 32'(bus.ack_out), 32'd1);
        check("swap pop data", 32'(bus.data_out), 32'h01);
        check("swap len", 32'(bus.len_out), 32'(DEPTH));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        check("rst in ACK ack", 32'(bus.ack_out), 32'd0);
        check("rst in ACK len", 32'(bus.len_out), 32'd0);
        check("rst in ACK dout", 32'(bus.data_out), 32'd0);
        bus.data_in = 8'h77;
        tick();
        check("recapture ack", 32'(bus.ack_out), 32'd1);
        check("recapture len", 32'(bus.len_out), 32'd1);
        sb.push_back(8'h77);
        bus.enqueue_in = 1'b0;
        tick();
        tick();
        pop_word();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
